dbg_trace_tx: RTL and testbench



---
 rtl/dbg_trace_pkg.sv | 40 ++++
 rtl/trace_fifo.sv | 64 ++++++
 rtl/dbg_trace_tx.sv | 160 ++++++++++++++++
 tb/tb_dbg_trace_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_trace_pkg.sv
// Shared types for the debug trace transmitter: record layout, record types,
// serializer states and the record-to-byte mapping.
package dbg_trace_pkg;

    typedef enum logic [1:0] {
        TR_NONE = 2'b00,
        TR_REG  = 2'b01,
        TR_MEM  = 2'b10,
        TR_OVF  = 2'b11
    } trace_type_e;

    typedef struct packed {
        trace_type_e rec_type;
        logic [8:0]  addr;
        logic [31:0] data;
    } trace_rec_t;

    localparam int REC_BYTES = 6;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

    // Byte 0 carries the type and addr[8]; data goes out little-endian.
    function automatic logic [7:0] rec_byte(input trace_rec_t rec, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {rec.rec_type, 5'b0, rec.addr[8]};
            3'd1:    b = rec.addr[7:0];
            3'd2:    b = rec.data[7:0];
            3'd3:    b = rec.data[15:8];
            3'd4:    b = rec.data[23:16];
            3'd5:    b = rec.data[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with three ordered write lanes (valid lanes are packed into
// consecutive slots) and a single read port exposing the head entry.
module trace_fifo
    import dbg_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               push_vld,
    input  trace_rec_t [2:0]         push_rec,
    input  logic                     pop,
    output trace_rec_t               head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_rec_t mem_q [DEPTH];
    trace_rec_t mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] slot;
    logic [CW-1:0] n_push;

    // The caller never pushes more than the free slots nor pops when empty.
    always_comb begin
        mem_d  = mem_q;
        slot   = wr_ptr_q;
        n_push = '0;
        for (int i = 0; i < 3; i++) begin
            if (push_vld[i]) begin
                mem_d[slot] = push_rec[i];
                slot        = slot + AW'(1);
                n_push      = n_push + CW'(1);
            end
        end
        wr_ptr_d = slot;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + n_push - (pop ? CW'(1) : CW'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/dbg_trace_tx.sv
// Debug trace transmitter: qualifies write-back and store events, allocates
// FIFO slots (overflow marker first), counts drops and serializes 6-byte records.
module dbg_trace_tx
    import dbg_trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          reg_write_sig,
    input  logic [4:0]                    reg_num,
    input  logic [DATA_W-1:0]             reg_data,
    input  logic                          wr,
    input  logic [DM_ADDRESS-1:0]         addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_last,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_cnt,
    output ser_state_e                    dbg_state
);
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(REC_BYTES - 1);

    // Handshake: a byte transfers on a rising edge where tx_valid & tx_ready;
    // once raised, tx_valid/tx_data/tx_last hold until that transfer.

    logic             reg_ev, mem_ev;
    logic [CW-1:0]    avail;
    logic [2:0]       push_vld;
    trace_rec_t [2:0] push_rec;
    logic [1:0]       drops;
    logic [16:0]      drop_sum;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]    fifo_count_w;
    trace_rec_t       head;
    logic             pop;
    logic             fifo_empty;

    ser_state_e       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    trace_rec_t       cur_q, cur_d;

    // Slots are granted marker -> reg -> mem from the pre-edge free count.
    always_comb begin
        reg_ev   = en & reg_write_sig & (reg_num != 5'd0);
        mem_ev   = en & wr;
        avail    = CW'(FIFO_DEPTH) - fifo_count_w;
        push_vld = 3'b000;
        drops    = 2'd0;

        push_rec[0] = '{rec_type: TR_OVF, addr: 9'd0, data: {16'd0, drop_cnt_q}};
        push_rec[1] = '{rec_type: TR_REG, addr: {4'd0, reg_num}, data: reg_data};
        push_rec[2] = '{rec_type: TR_MEM, addr: addr, data: wr_data};

        if (drop_cnt_q != 16'd0 && avail != '0) begin
            push_vld[0] = 1'b1;
            avail       = avail - CW'(1);
        end
        if (reg_ev) begin
            if (avail != '0) begin
                push_vld[1] = 1'b1;
                avail       = avail - CW'(1);
            end else begin
                drops = drops + 2'd1;
            end
        end
        if (mem_ev) begin
            if (avail != '0) begin
                push_vld[2] = 1'b1;
            end else begin
                drops = drops + 2'd1;
            end
        end

        drop_sum   = {1'b0, (push_vld[0] ? 16'd0 : drop_cnt_q)} + {15'd0, drops};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    trace_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count_w)
    );

    assign fifo_empty = (fifo_count_w == '0);

    // Serializer: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SER_IDLE;
            idx_q      <= 3'd0;
            cur_q      <= '0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Serializer: next state. The last-byte handshake pops straight into the
    // next record so back-to-back records have no bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SER_SEND;
                    idx_d   = 3'd0;
                    cur_d   = head;
                end
            end
            SER_SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = 3'd0;
                        if (!fifo_empty) begin
                            pop   = 1'b1;
                            cur_d = head;
                        end else begin
                            state_d = SER_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Serializer: outputs.
    always_comb begin
        tx_valid = (state_q == SER_SEND);
        tx_data  = tx_valid ? rec_byte(cur_q, idx_q) : 8'h00;
        tx_last  = tx_valid && (idx_q == LAST_IDX);
    end

    assign fifo_count = fifo_count_w;
    assign drop_cnt   = drop_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dbg_trace_tx.sv
// Bench for dbg_trace_tx: directed scenarios plus a randomized run, all
// checked against a queue-based record model of the transmitter.
module tb_dbg_trace_tx;
    import dbg_trace_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, reg_write_sig, wr, tx_ready;
    logic [4:0]  reg_num;
    logic [31:0] reg_data, wr_data;
    logic [8:0]  addr;
    logic        tx_valid, tx_last;
    logic [7:0]  tx_data;
    logic [3:0]  fifo_count;
    logic [15:0] drop_cnt;
    ser_state_e  dbg_state;

    always #5 clk = ~clk;

    dbg_trace_tx #(.FIFO_DEPTH(DEPTH), .DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .en(en), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .addr(addr),
        .wr_data(wr_data), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .fifo_count(fifo_count),
        .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    bit          got_last_q[$];

    // Model: records waiting in the FIFO, the record being sent, drop counter.
    logic [47:0] mq[$];
    bit          m_busy;
    int          m_idx;
    logic [47:0] m_cur;
    int          m_drop;

    function automatic logic [47:0] mk_rec(input logic [1:0] t, input logic [8:0] a,
                                           input logic [31:0] d);
        return {d, a[7:0], t, 5'b0, a[8]};
    endfunction

    task automatic model_push(input logic [47:0] r);
        mq.push_back(r);
        for (int i = 0; i < 6; i++) exp_q.push_back(r[8*i +: 8]);
    endtask

    task automatic model_reset();
        mq.delete(); exp_q.delete(); got_q.delete(); got_last_q.delete();
        m_busy = 0; m_idx = 0; m_cur = '0; m_drop = 0;
    endtask

    task automatic model_edge(input bit e, input bit rws, input logic [4:0] rn,
                              input logic [31:0] rd, input bit w, input logic [8:0] a,
                              input logic [31:0] wd, input bit rdy);
        int  n     = mq.size();
        int  free  = DEPTH - n;
        int  lost  = 0;
        bit  hs, last, pop, mk;
        pop  = (n > 0) && (!m_busy || (m_idx == 5 && rdy));
        hs   = m_busy && rdy;
        last = hs && (m_idx == 5);
        if (hs && !last) m_idx++;
        if (pop) begin
            m_cur  = mq.pop_front();
            m_busy = 1;
            m_idx  = 0;
        end else if (last) begin
            m_busy = 0;
        end
        mk = (m_drop != 0) && (free > 0);
        if (mk) begin
            model_push(mk_rec(2'b11, 9'd0, 32'(m_drop)));
            free--;
        end
        if (e && rws && rn != 0) begin
            if (free > 0) begin model_push(mk_rec(2'b01, {4'd0, rn}, rd)); free--; end
            else lost++;
        end
        if (e && w) begin
            if (free > 0) begin model_push(mk_rec(2'b10, a, wd)); free--; end
            else lost++;
        end
        m_drop = (mk ? 0 : m_drop) + lost;
        if (m_drop > 65535) m_drop = 65535;
    endtask

    task automatic step(input bit e, input bit rws, input logic [4:0] rn,
                        input logic [31:0] rd, input bit w, input logic [8:0] a,
                        input logic [31:0] wd, input bit rdy);
        en = e; reg_write_sig = rws; reg_num = rn; reg_data = rd;
        wr = w; addr = a; wr_data = wd; tx_ready = rdy;
        @(negedge clk);
        if (tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            got_last_q.push_back(tx_last);
        end
        @(posedge clk);
        model_edge(e, rws, rn, rd, w, a, wd, rdy);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 5'd0, 32'd0, 0, 9'd0, 32'd0, rdy);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (mq.size() == 0 && !m_busy && !tx_valid) break;
            idle(1);
        end
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain_timeout tx_valid=%0b required=0", name, tx_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 0; reg_write_sig = 0; reg_num = 0; reg_data = 0;
        wr = 0; addr = 0; wr_data = 0; tx_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%02h exp=00", tx_data); end
        vectors++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last got=%0b exp=0", tx_last); end
        vectors++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got=%0b exp=0", tx_valid); end
    endtask

    task automatic test_single_reg();
        logic [7:0] want [6] = '{8'h40, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        step(1, 1, 5'd5, 32'hDEADBEEF, 0, 9'd0, 32'd0, 1);
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_valid_at_capture got=%0b exp=0", tx_valid); end
        vectors++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_fifo_count got=%0d exp=1", fifo_count); end
        idle(1);
        vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h40) begin
            errors++; $display("FAIL single_first_byte got=%0b/%02h exp=1/40", tx_valid, tx_data);
        end
        drain("single");
        vectors++; if (got_q.size() != 6) begin errors++; $display("FAIL single_len got=%0d exp=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== want[i] || got_last_q[i] !== (i == 5)) begin
                errors++; $display("FAIL single_byte%0d got=%02h/last%0b exp=%02h/last%0b", i, got_q[i], got_last_q[i], want[i], i == 5);
            end
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    task automatic test_filter();
        step(1, 1, 5'd0, 32'h1234, 0, 9'd0, 32'd0, 1);
        vectors++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL x0_fifo_count got=%0d exp=0", fifo_count); end
        step(0, 0, 5'd0, 32'd0, 1, 9'h010, 32'h55, 1);
        vectors++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL en0_fifo_count got=%0d exp=0", fifo_count); end
        vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL en0_drop_cnt got=%0d exp=0", drop_cnt); end
        idle(1); idle(1);
        vectors++; if (tx_valid !== 1'b0 || got_q.size() != 0) begin
            errors++; $display("FAIL filter_no_record got valid=%0b bytes=%0d exp 0/0", tx_valid, got_q.size());
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    task automatic test_simul();
        logic [7:0] want [12] = '{8'h40, 8'h03, 8'h11, 8'h00, 8'h00, 8'h00,
                                  8'h81, 8'hF4, 8'h22, 8'h00, 8'h00, 8'h00};
        step(1, 1, 5'd3, 32'h11, 1, 9'h1F4, 32'h22, 1);
        vectors++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL simul_fifo_count got=%0d exp=2", fifo_count); end
        drain("simul");
        vectors++; if (got_q.size() != 12) begin errors++; $display("FAIL simul_len got=%0d exp=12", got_q.size()); end
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== want[i] || got_last_q[i] !== (i % 6 == 5)) begin
                errors++; $display("FAIL simul_byte%0d got=%02h/last%0b exp=%02h/last%0b", i, got_q[i], got_last_q[i], want[i], i % 6 == 5);
            end
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] d = $urandom;
        step(1, 1, 5'd7, d, 0, 9'd0, 32'd0, 1);
        idle(1); idle(1); idle(1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) step(1, 0, 5'd0, 32'd0, 1, 9'(($urandom_range(0, 511))), $urandom, 0);
            else idle(0);
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== d[7:0] || tx_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got=%0b/%02h/%0b exp=1/%02h/0", i, tx_valid, tx_data, tx_last, d[7:0]);
            end
        end
        drain("bp");
        vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % 6 == 5)) begin
                errors++; $display("FAIL bp_byte%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [7:0] want [6] = '{8'hC0, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        int n;
        // One record moves into the serializer, eight fill the FIFO, three are lost.
        for (int i = 0; i < 12; i++) step(1, 1, 5'(i + 1), $urandom, 0, 9'd0, 32'd0, 0);
        vectors++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_fifo_count got=%0d exp=8", fifo_count); end
        vectors++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt); end
        repeat (6) idle(1);
        vectors++; if (fifo_count !== 4'd7 || drop_cnt !== 16'd3) begin
            errors++; $display("FAIL ovf_after_pop got=%0d/%0d exp=7/3", fifo_count, drop_cnt);
        end
        idle(1);
        vectors++; if (fifo_count !== 4'd8 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL ovf_marker_push got=%0d/%0d exp=8/0", fifo_count, drop_cnt);
        end
        drain("ovf");
        vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
        end
        n = got_q.size();
        for (int i = 0; i < 6 && n >= 6; i++) begin
            vectors++;
            if (got_q[n-6+i] !== want[i]) begin errors++; $display("FAIL ovf_marker_byte%0d got=%02h exp=%02h", i, got_q[n-6+i], want[i]); end
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        step(1, 1, 5'd9, $urandom, 0, 9'd0, 32'd0, 1);
        step(1, 1, 5'd10, $urandom, 0, 9'd0, 32'd0, 1);
        idle(1); idle(1); idle(1);
        reset = 1'b1;
        #1;
        vectors++; if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs got=%0b/%0b/%02h exp=0/0/00", tx_valid, tx_last, tx_data);
        end
        vectors++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rstmid_fifo_count got=%0d exp=0", fifo_count); end
        #2;
        reset = 1'b0;
        model_reset();
        repeat (8) idle(1);
        vectors++; if (got_q.size() != 0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_resume got bytes=%0d valid=%0b exp 0/0", got_q.size(), tx_valid);
        end
        step(0, 0, 5'd0, 32'd0, 1, 9'h0AB, 32'hCAFE0001, 1);
        drain("rstmid");
        vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit rdy;
        for (int c = 0; c < 500; c++) begin
            rdy = (c >= 150 && c < 260) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                 $urandom, $urandom_range(0, 2) == 0, 9'($urandom_range(0, 511)), $urandom, rdy);
            vectors++;
            if (fifo_count !== 4'(mq.size()) || drop_cnt !== 16'(m_drop)) begin
                errors++; $display("FAIL rand_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, fifo_count, drop_cnt, mq.size(), m_drop);
            end
            vectors++;
            if (tx_valid !== m_busy || tx_last !== (m_busy && m_idx == 5) ||
                (m_busy && tx_data !== m_cur[8*m_idx +: 8])) begin
                errors++; $display("FAIL rand_tx c=%0d got=%0b/%0b/%02h exp=%0b/%0b/%02h", c, tx_valid, tx_last, tx_data,
                                   m_busy, m_busy && m_idx == 5, m_busy ? m_cur[8*m_idx +: 8] : 8'h00);
            end
        end
        drain("rand");
        vectors++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % 6 == 5)) begin
                errors++; $display("FAIL rand_byte%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete(); got_last_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_filter();
        test_simul();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
